// File: rtl/wb_write_arbiter.sv
// ============================================================================
//  Module   : wb_write_arbiter
//  Purpose  : Writeback-stage arbiter owning the single register-file write
//             port. The in-order pipeline writeback has fixed priority and is
//             never stalled. Long-latency (mul/div) results arrive over a
//             valid/ready handshake. When the port is busy they are buffered in
//             a small FIFO. Write outputs are registered, so a selected write
//             reaches the register file one cycle after it is selected.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             pipeWe_i/pipeRd_i/pipeData_i - pipeline writeback
//             luValid_i/luRd_i/luData_i, luReady_o - long-latency handshake
//             writeReg_o/writeData_o/regWrite_o - register file write port
//             fifoCount_o       - occupied FIFO slots (squashed slots included)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pipeWe_i,
  input  logic [AW-1:0]                  pipeRd_i,
  input  logic [DW-1:0]                  pipeData_i,
  input  logic                           luValid_i,
  output logic                           luReady_o,
  input  logic [AW-1:0]                  luRd_i,
  input  logic [DW-1:0]                  luData_i,
  output logic [AW-1:0]                  writeReg_o,
  output logic [DW-1:0]                  writeData_o,
  output logic                           regWrite_o,
  output logic [$clog2(DEPTH+1)-1:0]     fifoCount_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // FIFO storage; valid bits are cleared by squash, slots are freed by pop
  logic [AW-1:0]    rd_q   [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic             regWrite_q, regWrite_d;
  logic [AW-1:0]    writeReg_q, writeReg_d;
  logic [DW-1:0]    writeData_q, writeData_d;

  logic pipe_wr, empty, head_vld, accept, lu_squash, bypass, pop, push;

  // Ready depends only on registered occupancy, never on this cycle's pop
  assign luReady_o   = !rst && (count_q != FULL_CNT);
  assign accept      = luValid_i && luReady_o;
  assign pipe_wr     = pipeWe_i && (pipeRd_i != '0);
  assign empty       = (count_q == '0);
  assign head_vld    = !empty && vld_q[head_q];
  // A lu result is always older than a concurrent pipe write to the same rd
  assign lu_squash   = accept && pipe_wr && (luRd_i == pipeRd_i);
  assign bypass      = accept && !pipe_wr && empty && (luRd_i != '0);
  // A valid head pops only when it wins the port; an invalid head always pops
  assign pop         = !empty && (!vld_q[head_q] || !pipe_wr);
  assign push        = accept && (luRd_i != '0) && !bypass && !lu_squash;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    regWrite_d  = 1'b0;
    writeReg_d  = writeReg_q;
    writeData_d = writeData_q;
    head_d      = pop  ? ptr_inc(head_q) : head_q;
    tail_d      = push ? ptr_inc(tail_q) : tail_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    if (pipe_wr) begin
      regWrite_d  = 1'b1;
      writeReg_d  = pipeRd_i;
      writeData_d = pipeData_i;
    end else if (head_vld) begin
      regWrite_d  = 1'b1;
      writeReg_d  = rd_q[head_q];
      writeData_d = data_q[head_q];
    end else if (bypass) begin
      regWrite_d  = 1'b1;
      writeReg_d  = luRd_i;
      writeData_d = luData_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regWrite_q  <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      vld_q       <= '0;
    end else begin
      regWrite_q  <= regWrite_d;
      writeReg_q  <= writeReg_d;
      writeData_q <= writeData_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_wr && (rd_q[i] == pipeRd_i)) begin
          vld_q[i] <= 1'b0;
        end
      end
      // Pushed rd never matches a concurrent pipe rd (that case is squashed)
      if (push) begin
        vld_q[tail_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q]   <= luRd_i;
      data_q[tail_q] <= luData_i;
    end
  end

  assign regWrite_o  = regWrite_q;
  assign writeReg_o  = writeReg_q;
  assign writeData_o = writeData_q;
  assign fifoCount_o = count_q;

endmodule

`default_nettype wire
